// File: rtl/multi_gate_accum_pkg.sv
// Shared definitions for the multi-input gate accumulator: op encoding, FSM states,
// and helpers that split an op into its base reduction and its final inversion.
package multi_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

    typedef enum logic [1:0] {BASE_AND, BASE_OR, BASE_XOR} base_op_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

    function automatic logic is_inverting(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic base_op_t base_of(input logic [2:0] op);
        case (op)
            OP_OR, OP_NOR:   return BASE_OR;
            OP_XOR, OP_XNOR: return BASE_XOR;
            default:         return BASE_AND;
        endcase
    endfunction

endpackage

// File: rtl/multi_gate_accum_if.sv
// Operand and result valid/ready streams of the gate accumulator.
interface multi_gate_accum_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);

    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/gate_reduce_step.sv
// One pairwise step of the bitwise reduction; inversion is applied later, once.
module gate_reduce_step
    import multi_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] in_data,
    input  base_op_t         base,
    output logic [WIDTH-1:0] acc_nxt
);

    always_comb begin
        case (base)
            BASE_OR:  acc_nxt = acc | in_data;
            BASE_XOR: acc_nxt = acc ^ in_data;
            default:  acc_nxt = acc & in_data;
        endcase
    end

endmodule

// File: rtl/multi_gate_accum.sv
// N-operand, W-bit gate engine: collects NUM_OPS operands over a stream, reduces them
// with the selected gate, and presents the result on an output stream.
module multi_gate_accum
    import multi_gate_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OPS = 3,
    localparam int CNTW    = $clog2(NUM_OPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    multi_gate_accum_if.slave    bus,
    output logic                 busy,
    output logic                 err,
    output logic [CNTW-1:0]      op_cnt
);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NUM_OPS - 1);

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] step_out;
    logic [WIDTH-1:0] acc_nxt;
    base_op_t         base_q;
    logic             in_hs;
    logic             last_hs;

    assign base_q  = base_of(op_q);
    assign in_hs   = bus.in_valid && bus.in_ready;
    assign last_hs = in_hs && (op_cnt == LAST_CNT);

    gate_reduce_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .in_data (bus.in_data),
        .base    (base_q),
        .acc_nxt (step_out)
    );

    // The first operand seeds the accumulator instead of being combined with stale state.
    assign acc_nxt      = (op_cnt == '0) ? bus.in_data : step_out;
    assign bus.out_data = out_data_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_legal(op)) state_nxt = COLLECT;
            end
            COLLECT: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (last_hs) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= 3'd0;
            acc        <= '0;
            out_data_q <= '0;
            op_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == IDLE) && start && !is_legal(op);
            case (state)
                IDLE: begin
                    if (start && is_legal(op)) begin
                        op_q   <= op;
                        op_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (in_hs) begin
                        acc    <= acc_nxt;
                        op_cnt <= op_cnt + CNTW'(1);
                        if (last_hs)
                            out_data_q <= is_inverting(op_q) ? ~acc_nxt : acc_nxt;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) op_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_gate_accum.sv
// Directed bench for multi_gate_accum: an 8-bit instance for the main scenarios and a
// 1-bit instance swept against the plain gate truth tables.
module tb_multi_gate_accum;
    import multi_gate_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic       start8 = 1'b0, busy8, err8;
    logic [2:0] op8 = 3'd0;
    logic [1:0] cnt8;
    multi_gate_accum_if #(.WIDTH(8)) b8 ();

    logic       start1 = 1'b0, busy1, err1;
    logic [2:0] op1 = 3'd0;
    logic [1:0] cnt1;
    multi_gate_accum_if #(.WIDTH(1)) b1 ();

    multi_gate_accum #(.WIDTH(8), .NUM_OPS(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .bus(b8),
        .busy(busy8), .err(err8), .op_cnt(cnt8)
    );

    multi_gate_accum #(.WIDTH(1), .NUM_OPS(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .bus(b1),
        .busy(busy1), .err(err1), .op_cnt(cnt1)
    );

    function automatic logic gate_ref(input logic [2:0] o, input logic a, b, c);
        case (o)
            3'd0:    return a & b & c;
            3'd1:    return a | b | c;
            3'd2:    return ~(a & b & c);
            3'd3:    return ~(a | b | c);
            3'd4:    return a ^ b ^ c;
            default: return ~(a ^ b ^ c);
        endcase
    endfunction

    // Runs one 8-bit transaction, holding out_ready low for `hold` cycles before consuming.
    task automatic txn8(input logic [2:0] o, input logic [7:0] a, b, c,
                        input logic [7:0] exp, input int hold, input string name);
        logic [7:0] ops [3];
        ops[0] = a; ops[1] = b; ops[2] = c;
        @(negedge clk);
        start8 = 1'b1; op8 = o;
        @(negedge clk);
        start8 = 1'b0;
        vectors++;
        if (b8.in_ready !== 1'b1 || busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s collect: in_ready=%b busy=%b, expected 1 1", name, b8.in_ready, busy8);
        end
        for (int i = 0; i < 3; i++) begin
            b8.in_valid = 1'b1; b8.in_data = ops[i];
            @(negedge clk);
        end
        b8.in_valid = 1'b0;
        vectors++;
        if (b8.out_valid !== 1'b1 || b8.out_data !== exp || cnt8 !== 2'd3) begin
            miscompares++;
            $display("FAIL %s result: out_valid=%b out_data=%h op_cnt=%0d, expected 1 %h 3",
                     name, b8.out_valid, b8.out_data, cnt8, exp);
        end
        for (int k = 0; k < hold; k++) begin
            if (k == 1) begin start8 = 1'b1; op8 = OP_OR; end
            @(negedge clk);
            start8 = 1'b0;
            vectors++;
            if (b8.out_valid !== 1'b1 || b8.out_data !== exp || busy8 !== 1'b1) begin
                miscompares++;
                $display("FAIL %s hold%0d: out_valid=%b out_data=%h busy=%b, expected 1 %h 1",
                         name, k, b8.out_valid, b8.out_data, busy8, exp);
            end
        end
        b8.out_ready = 1'b1;
        @(negedge clk);
        b8.out_ready = 1'b0;
        vectors++;
        if (b8.out_valid !== 1'b0 || busy8 !== 1'b0 || cnt8 !== 2'd0 ||
            b8.in_ready !== 1'b0 || b8.out_data !== exp) begin
            miscompares++;
            $display("FAIL %s release: out_valid=%b busy=%b op_cnt=%0d in_ready=%b out_data=%h, expected 0 0 0 0 %h",
                     name, b8.out_valid, busy8, cnt8, b8.in_ready, b8.out_data, exp);
        end
    endtask

    task automatic txn1(input logic [2:0] o, input logic a, b, c, input bit gaps);
        logic ops [3];
        logic exp;
        ops[0] = a; ops[1] = b; ops[2] = c;
        exp = gate_ref(o, a, b, c);
        @(negedge clk);
        start1 = 1'b1; op1 = o;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (gaps) begin
                b1.in_valid = 1'b0; b1.in_data = ~ops[i];
                @(negedge clk);
            end
            b1.in_valid = 1'b1; b1.in_data = ops[i];
            @(negedge clk);
        end
        b1.in_valid = 1'b0;
        vectors++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== exp) begin
            miscompares++;
            $display("FAIL w1 op%0d abc=%b%b%b gaps=%0d: out_valid=%b out_data=%b, expected 1 %b",
                     o, a, b, c, gaps, b1.out_valid, b1.out_data, exp);
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (b8.in_ready !== 1'b0 || b8.out_valid !== 1'b0 || b8.out_data !== 8'h00 ||
            busy8 !== 1'b0 || err8 !== 1'b0 || cnt8 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h busy=%b err=%b op_cnt=%0d, expected all 0",
                     b8.in_ready, b8.out_valid, b8.out_data, busy8, err8, cnt8);
        end
    endtask

    task automatic test_and_nand();
        txn8(OP_AND,  8'hFF, 8'h0F, 8'h3C, 8'h0C, 0, "and");
        txn8(OP_NAND, 8'hFF, 8'h0F, 8'h3C, 8'hF3, 0, "nand");
    endtask

    task automatic test_xor_family();
        txn8(OP_XOR,  8'hA5, 8'h5A, 8'hFF, 8'h00, 0, "xor");
        txn8(OP_XNOR, 8'hA5, 8'h5A, 8'hFF, 8'hFF, 0, "xnor");
        txn8(OP_NOR,  8'h01, 8'h02, 8'h04, 8'hF8, 0, "nor");
    endtask

    task automatic test_back_pressure();
        txn8(OP_AND, 8'hFF, 8'h0F, 8'h3C, 8'h0C, 5, "backpressure");
        @(negedge clk);
        vectors++;
        if (busy8 !== 1'b0 || b8.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_start_ignored: busy=%b in_ready=%b, expected 0 0", busy8, b8.in_ready);
        end
    endtask

    task automatic test_illegal();
        for (int v = 6; v <= 7; v++) begin
            @(negedge clk);
            start8 = 1'b1; op8 = 3'(v);
            @(negedge clk);
            start8 = 1'b0;
            vectors++;
            if (err8 !== 1'b1 || b8.in_ready !== 1'b0 || busy8 !== 1'b0 || b8.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal%0d pulse: err=%b in_ready=%b busy=%b out_valid=%b, expected 1 0 0 0",
                         v, err8, b8.in_ready, busy8, b8.out_valid);
            end
            @(negedge clk);
            vectors++;
            if (err8 !== 1'b0 || busy8 !== 1'b0 || b8.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal%0d after: err=%b busy=%b out_valid=%b, expected 0 0 0",
                         v, err8, busy8, b8.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start8 = 1'b1; op8 = OP_AND;
        @(negedge clk);
        start8 = 1'b0;
        b8.in_valid = 1'b1; b8.in_data = 8'h0F;
        @(negedge clk);
        b8.in_data = 8'h03;
        @(negedge clk);
        b8.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (b8.in_ready !== 1'b0 || cnt8 !== 2'd0 || busy8 !== 1'b0 || b8.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: in_ready=%b op_cnt=%0d busy=%b out_valid=%b, expected 0 0 0 0",
                     b8.in_ready, cnt8, busy8, b8.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn8(OP_OR, 8'h10, 8'h20, 8'h40, 8'h70, 0, "or_after_reset");
    endtask

    task automatic test_width1();
        for (int o = 0; o < 6; o++)
            for (int i = 0; i < 8; i++) begin
                logic [2:0] abc;
                abc = 3'(i);
                txn1(3'(o), abc[2], abc[1], abc[0], 1'b0);
                if (o < 4) txn1(3'(o), abc[2], abc[1], abc[0], 1'b1);
            end
    endtask

    initial begin
        b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_and_nand();
        test_xor_family();
        test_back_pressure();
        test_illegal();
        test_reset_mid();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
